crossbar_arbiter: RTL and testbench

CROSSBAR_ARBITER -- requirements
Module: crossbar_arbiter

---
 rtl/crossbar_arbiter.sv | 124 ++++++++++++
 tb/tb_crossbar_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_arbiter.sv
// Round-robin N:1 stream arbiter with a single registered output stage.
// Define CROSSBAR_ARB_TLAST_LOCK_EN to hold the grant for a whole packet.
module crossbar_arbiter #(
    parameter  int NUM_PORTS  = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int ID_WIDTH   = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_PORTS-1:0]            s_axis_data_tvalid,
    output logic [NUM_PORTS-1:0]            s_axis_data_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_data_tdata,
`ifdef CROSSBAR_ARB_TLAST_LOCK_EN
    input  logic [NUM_PORTS-1:0]            s_axis_data_tlast,
    output logic                            m_axis_data_tlast,
`endif
    output logic                            m_axis_data_tvalid,
    input  logic                            m_axis_data_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_data_tdata,
    output logic [ID_WIDTH-1:0]             m_axis_data_tid
);

    localparam logic [ID_WIDTH:0]   NP   = (ID_WIDTH+1)'(NUM_PORTS);
    localparam logic [ID_WIDTH-1:0] LAST = ID_WIDTH'(NUM_PORTS-1);

    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH-1:0]   next_ptr;
    logic                  grant_vld;
    logic                  load;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [ID_WIDTH:0]     sum;

`ifdef CROSSBAR_ARB_TLAST_LOCK_EN
    logic                locked;
    logic [ID_WIDTH-1:0] lock_id;
    logic                sel_last;
`endif

    assign load   = !m_axis_data_tvalid || m_axis_data_tready;
    assign accept = load && grant_vld && resetn;

    // Walk downward so the port closest to rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        sum       = '0;
        for (int k = NUM_PORTS-1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
            if (sum >= NP)
                sum = sum - NP;
            if (s_axis_data_tvalid[sum[ID_WIDTH-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = sum[ID_WIDTH-1:0];
            end
        end
`ifdef CROSSBAR_ARB_TLAST_LOCK_EN
        if (locked) begin
            grant_id  = lock_id;
            grant_vld = s_axis_data_tvalid[lock_id];
        end
`endif
    end

    always_comb begin
        sel_data           = '0;
        s_axis_data_tready = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (grant_id == ID_WIDTH'(k)) begin
                sel_data              = s_axis_data_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                s_axis_data_tready[k] = accept;
            end
        end
    end

`ifdef CROSSBAR_ARB_TLAST_LOCK_EN
    assign sel_last = s_axis_data_tlast[grant_id];
`endif

    assign next_ptr = (grant_id == LAST) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_axis_data_tvalid <= 1'b0;
            m_axis_data_tid    <= '0;
            rr_ptr             <= '0;
`ifdef CROSSBAR_ARB_TLAST_LOCK_EN
            locked             <= 1'b0;
            lock_id            <= '0;
`endif
        end else begin
            if (load) begin
                m_axis_data_tvalid <= accept;
                if (accept)
                    m_axis_data_tid <= grant_id;
            end
            if (accept) begin
`ifdef CROSSBAR_ARB_TLAST_LOCK_EN
                if (sel_last) begin
                    rr_ptr <= next_ptr;
                    locked <= 1'b0;
                end else begin
                    locked  <= 1'b1;
                    lock_id <= grant_id;
                end
`else
                rr_ptr <= next_ptr;
`endif
            end
        end
    end

    // Payload is left unreset; it is qualified by m_axis_data_tvalid.
    always_ff @(posedge clk) begin
        if (accept) begin
            m_axis_data_tdata <= sel_data;
`ifdef CROSSBAR_ARB_TLAST_LOCK_EN
            m_axis_data_tlast <= sel_last;
`endif
        end
    end

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Directed bench for crossbar_arbiter (4 ports, 32-bit payload).
// Packet-lock vectors run only when CROSSBAR_ARB_TLAST_LOCK_EN is defined.
module tb_crossbar_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk;
    logic            resetn;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N*DW-1:0] s_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic [DW-1:0]   m_tdata;
    logic [1:0]      m_tid;
`ifdef CROSSBAR_ARB_TLAST_LOCK_EN
    logic [N-1:0]    s_tlast;
    logic            m_tlast;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    crossbar_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .s_axis_data_tdata  (s_tdata),
`ifdef CROSSBAR_ARB_TLAST_LOCK_EN
        .s_axis_data_tlast  (s_tlast),
        .m_axis_data_tlast  (m_tlast),
`endif
        .m_axis_data_tvalid (m_tvalid),
        .m_axis_data_tready (m_tready),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tid    (m_tid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int p, input logic [DW-1:0] d);
        s_tdata[p*DW +: DW] = d;
    endtask

    initial begin
        resetn   = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        m_tready = 1'b1;
`ifdef CROSSBAR_ARB_TLAST_LOCK_EN
        s_tlast  = '0;
`endif
        tick();
        tick();
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tid", 32'(m_tid), 32'd0);
        s_tvalid = 4'hF;
        #1;
        check("rst_tready", 32'(s_tready), 32'd0);
        s_tvalid = '0;
        resetn   = 1'b1;
        #1;

        // single source on port 2
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 4'b0100;
            put(2, 32'hA0 + 32'(i));
            #1;
            if (i == 0)
                check("single_lat0", 32'(m_tvalid), 32'd0);
            check("single_tready", 32'(s_tready), 32'b0100);
            tick();
            check("single_tvalid", 32'(m_tvalid), 32'd1);
            check("single_tdata", m_tdata, 32'hA0 + 32'(i));
            check("single_tid", 32'(m_tid), 32'd2);
        end
        s_tvalid = '0;
        #1;
        check("single_idle_tready", 32'(s_tready), 32'd0);
        tick();
        check("single_drain", 32'(m_tvalid), 32'd0);

        // idle: pointer stays at 3 after the port-2 burst
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_tvalid", 32'(m_tvalid), 32'd0);
            check("idle_tready", 32'(s_tready), 32'd0);
        end
        s_tvalid = 4'hF;
        #1;
        check("idle_rr_hold", 32'(s_tready), 32'b1000);
        s_tvalid = '0;
        resetn   = 1'b0;
        tick();
        resetn = 1'b1;

        // all ports valid, output always ready
        for (int i = 0; i < N; i++)
            put(i, 32'hB0 + 32'(i));
        s_tvalid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_tvalid", 32'(m_tvalid), 32'd1);
            check("rr_tid", 32'(m_tid), 32'(k % 4));
            check("rr_tdata", m_tdata, 32'hB0 + 32'(k % 4));
        end
        s_tvalid = '0;
        tick();
        check("rr_drain", 32'(m_tvalid), 32'd0);

        // backpressure with ports 1 and 3 pending
        m_tready = 1'b0;
        put(1, 32'hC1);
        put(3, 32'hC3);
        s_tvalid = 4'b1010;
        #1;
        check("bp_first_tready", 32'(s_tready), 32'b0010);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_tvalid", 32'(m_tvalid), 32'd1);
            check("bp_tid", 32'(m_tid), 32'd1);
            check("bp_tdata", m_tdata, 32'hC1);
            check("bp_tready", 32'(s_tready), 32'd0);
            tick();
        end
        m_tready = 1'b1;
        #1;
        check("bp_resume_tready", 32'(s_tready), 32'b1000);
        tick();
        check("bp_resume_tid", 32'(m_tid), 32'd3);
        check("bp_resume_tdata", m_tdata, 32'hC3);
        s_tvalid = '0;
        tick();
        check("bp_drain", 32'(m_tvalid), 32'd0);

        // reset while holding a port-3 beat
        m_tready = 1'b0;
        put(3, 32'hD3);
        s_tvalid = 4'b1000;
        tick();
        check("mrst_hold_tvalid", 32'(m_tvalid), 32'd1);
        check("mrst_hold_tid", 32'(m_tid), 32'd3);
        resetn = 1'b0;
        put(0, 32'hD0);
        s_tvalid = 4'b1001;
        #1;
        check("mrst_tready", 32'(s_tready), 32'd0);
        tick();
        check("mrst_tvalid", 32'(m_tvalid), 32'd0);
        check("mrst_tid", 32'(m_tid), 32'd0);
        resetn   = 1'b1;
        m_tready = 1'b1;
        #1;
        check("mrst_first_grant", 32'(s_tready), 32'b0001);
        tick();
        check("mrst_out0_tid", 32'(m_tid), 32'd0);
        check("mrst_out0_tdata", m_tdata, 32'hD0);
        check("mrst_next_grant", 32'(s_tready), 32'b1000);
        tick();
        check("mrst_out3_tid", 32'(m_tid), 32'd3);
        check("mrst_out3_tdata", m_tdata, 32'hD3);
        s_tvalid = '0;
        tick();

`ifdef CROSSBAR_ARB_TLAST_LOCK_EN
        // single-beat packet from port 0 moves the pointer to 1
        put(0, 32'hE0);
        s_tlast  = 4'b0001;
        s_tvalid = 4'b0001;
        tick();
        check("lock_pre_tid", 32'(m_tid), 32'd0);
        put(1, 32'hF0);
        s_tvalid = 4'b0011;
        tick();
        check("lock_b0_tid", 32'(m_tid), 32'd1);
        check("lock_b0_tdata", m_tdata, 32'hF0);
        check("lock_b0_tlast", 32'(m_tlast), 32'd0);
        check("lock_b0_tready", 32'(s_tready), 32'b0010);
        put(1, 32'hF1);
        tick();
        check("lock_b1_tid", 32'(m_tid), 32'd1);
        check("lock_b1_tdata", m_tdata, 32'hF1);
        check("lock_b1_tready", 32'(s_tready), 32'b0010);
        put(1, 32'hF2);
        s_tlast = 4'b0011;
        tick();
        check("lock_b2_tid", 32'(m_tid), 32'd1);
        check("lock_b2_tdata", m_tdata, 32'hF2);
        check("lock_b2_tlast", 32'(m_tlast), 32'd1);
        check("lock_release", 32'(s_tready), 32'b0001);
        s_tvalid = 4'b0001;
        tick();
        check("lock_after_tid", 32'(m_tid), 32'd0);
        check("lock_after_tdata", m_tdata, 32'hE0);
        s_tvalid = '0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
